// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and
// a counter-width helper, reused by both the receive and transmit halves.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OVS_DEF     = 16;

    // Bits needed to count 0..max(a,b)-1; never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen so an idle-high line does not look like a start bit out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detection, centre sampling of DBIT
// data bits LSB-first, stop-bit check and a one-clock completion pulse.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | counting to the start-bit centre, rejecting glitches
//   DATA  | sampling one data bit every OVS ticks
//   STOP  | waiting SB_TICK ticks, then checking the stop level
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OVS     = OVS_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = cnt_width(OVS, SB_TICK);
    localparam int NW = cnt_width(DBIT, DBIT);

    localparam logic [SW-1:0] S_START_END = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT_END   = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    uart_state_t     state, state_nxt;
    logic [SW-1:0]   s, s_nxt;
    logic [NW-1:0]   n, n_nxt;
    logic [DBIT-1:0] b, b_nxt;
    logic [DBIT-1:0] dout_nxt;
    logic            ferr_nxt;
    logic            done_nxt;
    logic            rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            s            <= s_nxt;
            n            <= n_nxt;
            b            <= b_nxt;
            dout         <= dout_nxt;
            frame_err    <= ferr_nxt;
            rx_done_tick <= done_nxt;
        end
    end

    // IDLE leaves on the line level alone, so a start bit that began during
    // the previous stop tail is picked up the cycle after returning to IDLE.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        n_nxt     = n;
        b_nxt     = b;
        dout_nxt  = dout;
        ferr_nxt  = frame_err;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    s_nxt     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_START_END) begin
                        s_nxt = '0;
                        if (!rx_s) begin
                            state_nxt = DATA;
                            n_nxt     = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT_END) begin
                        s_nxt = '0;
                        b_nxt = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            n_nxt = n + 1'b1;
                        end
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP_END) begin
                        state_nxt = IDLE;
                        s_nxt     = '0;
                        dout_nxt  = b;
                        ferr_nxt  = ~rx_s;
                        done_nxt  = 1'b1;
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART, consuming the 16x oversampling tick from the baud rate generator. It detects a start bit on the asynchronous `rx` line and aligns sampling to bit centres. It assembles `DBIT` data bits LSB-first, checks the stop bit, and presents the byte with a one-clock completion pulse. It sits between the pad-side `rx` pin and the host-side interface logic.

## Interface
- `DBIT`, 8: data bits per frame, 5..8.
- `SB_TICK`, 16: oversampling ticks spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `OVS`, 16: ticks per bit; must equal the generator's `Ticks`.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  oversampling strobe from the baud generator, one `clk` wide.
- `rx`  in  1  serial line, asynchronous, idle high.
- `dout`  out  DBIT  last received byte.
- `rx_done_tick`  out  1  one-clock pulse when `dout` updates.
- `frame_err`  out  1  stop bit sampled low on the last frame.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1, giving `rx_s`. All decisions use `rx_s`.
- Internal registers:
  - `s`: tick counter, log2(max(OVS,SB_TICK)) bits.
  - `n`: bit counter, log2(DBIT) bits.
  - `b`: shift register, DBIT bits.
- **IDLE:** `rx_s`==0 → START, with s=0. No `s_tick` is needed for this transition.
- **START:** on each `s_tick`:
  - s==OVS/2-1 and `rx_s`==0 → DATA, s=0, n=0.
  - s==OVS/2-1 and `rx_s`==1 → IDLE (glitch rejected; no pulse, outputs unchanged).
  - otherwise s++.
- **DATA:** on each `s_tick`:
  - s==OVS-1 → s=0, b={rx_s, b[DBIT-1:1]}. Then n==DBIT-1 → STOP, else n++.
  - otherwise s++.
- **STOP:** on each `s_tick`:
  - s==SB_TICK-1 → IDLE, dout=b, frame_err=~rx_s, rx_done_tick=1.
  - otherwise s++.
- `dout` and `frame_err` hold their values until the next completed frame. A frame with a framing error still updates `dout`.
- Between ticks, all state, `s`, `n` and `b` hold.
- Counters never wrap. They reset at each transition above.

## Timing
- Reset values:
  - state IDLE, s=0, n=0, b=0.
  - dout=0, rx_done_tick=0, frame_err=0, busy=0.
  - both synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately: no pulse, and `dout` clears to 0.
- Latency from `rx` edge to `rx_s` is 2 `clk` cycles.
- `rx_done_tick` is registered:
  - it is high during the `clk` cycle following the edge that consumed the final STOP tick;
  - it is exactly one `clk` wide;
  - `dout` and `frame_err` are valid in that same cycle.
- Sampling points, measured from the start edge, are in ticks:
  - start bit checked at tick OVS/2;
  - data bit k sampled at OVS/2 + (k+1)·OVS;
  - stop bit sampled at OVS/2 + DBIT·OVS + SB_TICK.
- Back-to-back frames: the cycle after STOP → IDLE, a low `rx_s` starts the next frame. The next start bit is not missed even when it began during the stop-sample tail.
- `s_tick` coincident with the IDLE → START transition is not counted. Counting begins on the next tick.

## Structure
- Shared package/header `uart_pkg`:
  - state encoding localparams IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - default `DBIT`, `SB_TICK`, `OVS`.
  - The future `uart_tx` reuses the same package.
- One sub-module, `sync_2ff`: a parameterized reset value, here 1.
- The tick source is external and is not instantiated here.
- Single FSM plus datapath registers, 2-process style (state register and next-state logic).

## Test plan
- Generator at 100 MHz / 19200 baud × 16 driving `s_tick`. Send 0x55 with 1 stop bit → one `rx_done_tick`, `dout`=0x55, `frame_err`=0, pulse ≈ 9.5 bit-times after the start edge.
- Send 0xA3, then 0x0F, with no idle gap → two pulses, `dout` 0xA3 then 0x0F, both `frame_err`=0.
- Pull `rx` low for 4 ticks only, then high → state returns to IDLE, no pulse, `dout` unchanged.
- Send 0xC4 with the stop bit driven 0 → pulse, `dout`=0xC4, `frame_err`=1. A following good frame 0x12 clears `frame_err` to 0.
- Assert `reset_n` low mid-DATA after 3 bits of 0xFF, release, then send 0x3C → no pulse for the aborted frame, single pulse with `dout`=0x3C.
- `DBIT`=7, `SB_TICK`=32: send 7-bit 0x5A with 2 stop bits → `dout`=7'h5A, pulse 32 ticks after the last data sample.
